seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle 8-bit ALU.
- Width-generic datapath with a start/busy/done handshake.
- Logic and add-class ops complete in 1 cycle; shifts and rotates iterate one bit per cycle; unsigned multiply runs as a WIDTH-cycle shift-add.
- Sits between the decode stage and the register file; the control unit stalls on busy.

Parameters:
- WIDTH, 8: operand/result width. Power of 2, >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration-counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch op; sampled only in IDLE
- oper  in  4  opcode, latched at start
- a_in  in  WIDTH  operand A, latched at start
- b_in  in  WIDTH  operand B / shift count, latched at start
- flags_in  in  4  {V,N,Z,C} = bits [3:0] = {3,2,1,0}, latched at start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, results valid
- out_lo  out  WIDTH  result, low half
- out_hi  out  WIDTH  multiply high half; 0 for all other ops
- flags_out  out  4  updated flags, valid with done, held afterwards

Behaviour:
- Opcodes:
  - 0 add, 1 adc, 2 sub (A+~B+1), 3 sbc (A+~B+C), 4 cmp (as sub)
  - 5 and, 6 orr, 7 xor, 8 inv, 9 neg
  - A lsl, B lsr, C asr, D rol, E ror, F mul
- Reset: IDLE; busy=0, done=0, out_lo=0, out_hi=0, flags_out=0. Reset mid-operation aborts immediately with no done pulse.
- States:
  - IDLE -> EXEC on start.
  - EXEC -> FIN when remaining count == 0.
  - FIN asserts done for 1 cycle, then -> IDLE.
- Start handling: start outside IDLE is ignored; no queueing. start in the same cycle done is high is also ignored, because the FSM is in FIN.
- Outputs: out_lo, out_hi and flags_out change only on the FIN cycle and hold until the next FIN.
- Latency, counted from the start edge to the done-high edge:
  - 1-cycle ops (0-9), and any shift/rotate with an effective count of 0: 2 cycles.
  - Shift/rotate: 2+n cycles, n = effective count.
  - mul: 2+WIDTH cycles.
- Add class (0-3):
  - C = carry out of WIDTH-bit sum.
  - V = signed overflow.
  - N = msb of result; Z = (out_lo==0).
- cmp: flags as sub; out_lo/out_hi not updated (keep previous values).
- Logic (5-8): C and V pass from flags_in; N and Z from result.
- neg: two's complement; C=(a_in!=0); V=(a_in==100..0); N and Z from result.
- Shifts:
  - n = min(b_in, WIDTH).
  - Each iteration shifts 1 bit; C = bit shifted out on the last iteration.
  - asr replicates the msb; lsl/lsr fill 0.
  - V passes through; N and Z from result.
- Rotates: n = b_in mod WIDTH. C and V pass through; N and Z from result.
- Effective count 0 (shift or rotate): out_lo=a_in and flags_out=flags_in entirely, including Z.
- mul:
  - Unsigned A*B, 2*WIDTH-bit product: {out_hi,out_lo}.
  - One add-shift per cycle.
  - C = (out_hi!=0); Z = (product==0); N = msb of out_hi; V passes through.
- out_hi = 0 for every op except mul and cmp.
- Operand inputs may change after the start cycle without affecting the result.

Test Plan:
- WIDTH=8, add 8'hFF+8'h01, flags_in=0 -> done at cycle 2, out_lo=00, flags C=1,Z=1,N=0,V=0.
- sub 8'h80-8'h01 -> out_lo=7F, C=1, V=1, N=0, Z=0; then cmp 05,05 -> Z=1, C=1, out_lo still 7F.
- lsl A=8'h81, B=3 -> busy 4 cycles, done at cycle 5, out_lo=08, C=0; asr A=8'h80, B=20 -> out_lo=FF, C=1, n capped at 8.
- ror A=8'h01, B=9, flags_in C=1 -> n=1, out_lo=80, C=1, N=1; rol B=8 -> flags_out==flags_in, done at cycle 2.
- mul 8'hFF*8'hFF -> done at cycle 10, out_hi=FE, out_lo=01, C=1; second start asserted while busy -> ignored, no extra done.
- Assert rst_n low mid-mul -> outputs 0 asynchronously, no done; a fresh add after release completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered width-generic ALU with start/busy/done handshake; shifts iterate per bit, mul is shift-add
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       oper,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [3:0]       flags_out
);
    localparam int LOG_W = $clog2(WIDTH);
    localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4, OP_AND = 4'h5, OP_ORR = 4'h6, OP_XOR = 4'h7;
    localparam logic [3:0] OP_INV = 4'h8, OP_NEG = 4'h9, OP_LSL = 4'hA, OP_LSR = 4'hB;
    localparam logic [3:0] OP_ASR = 4'hC, OP_ROL = 4'hD, OP_ROR = 4'hE, OP_MUL = 4'hF;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

    state_t           state;
    logic [3:0]       op_r, flags_r, flags_n;
    logic [WIDTH-1:0] a_r, b_r, p_hi, bb, res;
    logic [WIDTH:0]   sum, mac;
    logic [CNT_W-1:0] cnt, n_in;
    logic             c_r, n0_r, cin, c_n, v_n, is_sr, is_sh_in, is_rot_in;

    assign is_sh_in  = oper inside {OP_LSL, OP_LSR, OP_ASR};
    assign is_rot_in = oper inside {OP_ROL, OP_ROR};
    // Shifts saturate at WIDTH, rotates wrap, mul always runs WIDTH steps
    assign n_in = is_sh_in ? ((b_in >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(b_in)) :
                  is_rot_in ? CNT_W'(b_in[LOG_W-1:0]) :
                  (oper == OP_MUL) ? CNT_W'(WIDTH) : '0;
    assign mac = {1'b0, p_hi} + {1'b0, (b_r[0] ? a_r : {WIDTH{1'b0}})};

    always_comb begin
        bb      = (op_r inside {OP_SUB, OP_SBC, OP_CMP}) ? ~b_r : b_r;
        cin     = (op_r inside {OP_SUB, OP_CMP}) | ((op_r inside {OP_ADC, OP_SBC}) & flags_r[0]);
        sum     = {1'b0, a_r} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        res     = sum[WIDTH-1:0];
        c_n     = flags_r[0];
        v_n     = flags_r[3];
        is_sr   = (op_r >= OP_LSL) && (op_r != OP_MUL);
        case (op_r)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                c_n = sum[WIDTH];
                v_n = (a_r[WIDTH-1] == bb[WIDTH-1]) && (res[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_AND: res = a_r & b_r;
            OP_ORR: res = a_r | b_r;
            OP_XOR: res = a_r ^ b_r;
            OP_INV: res = ~a_r;
            OP_NEG: begin
                res = -a_r;
                c_n = |a_r;
                v_n = (a_r == MIN_NEG);
            end
            OP_LSL, OP_LSR, OP_ASR: begin
                res = a_r;
                c_n = c_r;
            end
            OP_ROL, OP_ROR: res = a_r;
            default: res = b_r;
        endcase
        flags_n = (op_r == OP_MUL) ? {flags_r[3], p_hi[WIDTH-1], ~|{p_hi, b_r}, |p_hi} :
                  (is_sr && n0_r) ? flags_r :
                  {v_n, res[WIDTH-1], ~|res, c_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_lo    <= '0;
            out_hi    <= '0;
            flags_out <= '0;
            op_r      <= '0;
            flags_r   <= '0;
            a_r       <= '0;
            b_r       <= '0;
            p_hi      <= '0;
            cnt       <= '0;
            c_r       <= 1'b0;
            n0_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r    <= oper;
                    a_r     <= a_in;
                    b_r     <= b_in;
                    flags_r <= flags_in;
                    p_hi    <= '0;
                    c_r     <= 1'b0;
                    cnt     <= n_in;
                    n0_r    <= (n_in == '0);
                    busy    <= 1'b1;
                    state   <= EXEC;
                end
                EXEC: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                    case (op_r)
                        OP_LSL: begin
                            a_r <= a_r << 1;
                            c_r <= a_r[WIDTH-1];
                        end
                        OP_LSR: begin
                            a_r <= a_r >> 1;
                            c_r <= a_r[0];
                        end
                        OP_ASR: begin
                            a_r <= {a_r[WIDTH-1], a_r[WIDTH-1:1]};
                            c_r <= a_r[0];
                        end
                        OP_ROL: a_r <= {a_r[WIDTH-2:0], a_r[WIDTH-1]};
                        OP_ROR: a_r <= {a_r[0], a_r[WIDTH-1:1]};
                        OP_MUL: begin
                            p_hi <= mac[WIDTH:1];
                            b_r  <= {mac[0], b_r[WIDTH-1:1]};
                        end
                        default: ;
                    endcase
                end else begin
                    out_lo    <= (op_r == OP_CMP) ? out_lo : res;
                    out_hi    <= (op_r == OP_MUL) ? p_hi : (op_r == OP_CMP) ? out_hi : '0;
                    flags_out <= flags_n;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= FIN;
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu, scoreboard queue checked by a done-triggered monitor
module tb_seq_alu;
    logic       clk = 0, rst_n = 0, start = 0;
    logic [3:0] oper = 0, flags_in = 0;
    logic [7:0] a_in = 0, b_in = 0;
    logic       busy, done;
    logic [7:0] out_lo, out_hi;
    logic [3:0] flags_out;

    typedef struct {
        string      nm;
        logic [7:0] lo, hi;
        logic [3:0] fl;
        int         at, lat;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_fail = 0, cyc = 0, bcnt = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .a_in(a_in), .b_in(b_in),
        .flags_in(flags_in), .busy(busy), .done(done), .out_lo(out_lo), .out_hi(out_hi),
        .flags_out(flags_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) bcnt = 0;
        else begin
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.nm, "_lo"}, out_lo, e.lo);
                    chk({e.nm, "_hi"}, out_hi, e.hi);
                    chk({e.nm, "_flags"}, flags_out, e.fl);
                    chk({e.nm, "_latency"}, cyc, e.at);
                    chk({e.nm, "_busy_cycles"}, bcnt, e.lat - 1);
                end
                bcnt = 0;
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [3:0] fl, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        oper = op; a_in = a; b_in = b; flags_in = f; start = 1;
        e.nm = nm; e.lo = lo; e.hi = hi; e.fl = fl; e.lat = lat; e.at = cyc + lat;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 0; a_in = ~a; b_in = ~b; flags_in = ~f; oper = ~op;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk({nm, "_timeout"}, q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [3:0] fl, input int lat);
        issue(nm, op, a, b, f, lo, hi, fl, lat, 1);
        wait_done(nm);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_lo", out_lo, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        //        name     op     a      b      f_in     lo     hi     {V,N,Z,C} lat
        run("add",     4'h0, 8'hFF, 8'h01, 4'b0000, 8'h00, 8'h00, 4'b0011, 2);
        run("sub",     4'h2, 8'h80, 8'h01, 4'b0000, 8'h7F, 8'h00, 4'b1001, 2);
        run("cmp",     4'h4, 8'h05, 8'h05, 4'b0000, 8'h7F, 8'h00, 4'b0011, 2);
        run("adc",     4'h1, 8'h7F, 8'h00, 4'b0001, 8'h80, 8'h00, 4'b1100, 2);
        run("sbc",     4'h3, 8'h10, 8'h05, 4'b0000, 8'h0A, 8'h00, 4'b0001, 2);
        run("and",     4'h5, 8'hF0, 8'h3C, 4'b1001, 8'h30, 8'h00, 4'b1001, 2);
        run("orr",     4'h6, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 4'b0010, 2);
        run("xor",     4'h7, 8'hAA, 8'hFF, 4'b0001, 8'h55, 8'h00, 4'b0001, 2);
        run("inv",     4'h8, 8'h0F, 8'h00, 4'b1000, 8'hF0, 8'h00, 4'b1100, 2);
        run("neg_min", 4'h9, 8'h80, 8'h00, 4'b0000, 8'h80, 8'h00, 4'b1101, 2);
        run("neg_0",   4'h9, 8'h00, 8'h00, 4'b1111, 8'h00, 8'h00, 4'b0010, 2);
        run("lsl",     4'hA, 8'h81, 8'h03, 4'b0000, 8'h08, 8'h00, 4'b0000, 5);
        run("asr_cap", 4'hC, 8'h80, 8'h14, 4'b0000, 8'hFF, 8'h00, 4'b0101, 10);
        run("lsr",     4'hB, 8'h81, 8'h01, 4'b1000, 8'h40, 8'h00, 4'b1001, 3);
        run("lsr_all", 4'hB, 8'h01, 8'h08, 4'b0000, 8'h00, 8'h00, 4'b0010, 10);
        run("ror",     4'hE, 8'h01, 8'h09, 4'b0001, 8'h80, 8'h00, 4'b0101, 3);
        run("rol_n0",  4'hD, 8'h00, 8'h08, 4'b0100, 8'h00, 8'h00, 4'b0100, 2);
        run("rol",     4'hD, 8'h81, 8'h02, 4'b0000, 8'h06, 8'h00, 4'b0000, 4);
        // start while busy must be dropped: the monitor flags any extra done
        issue("mul_ff", 4'hF, 8'hFF, 8'hFF, 4'b0000, 8'h01, 8'hFE, 4'b0101, 10, 1);
        repeat (2) @(negedge clk);
        chk("mul_busy", busy, 1);
        oper = 4'h0; a_in = 8'h11; b_in = 8'h22; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("mul_ff");
        repeat (3) @(negedge clk);
        run("mul_0",   4'hF, 8'h00, 8'h37, 4'b1000, 8'h00, 8'h00, 4'b1010, 10);
        run("mul_small", 4'hF, 8'h0D, 8'h0B, 4'b0000, 8'h8F, 8'h00, 4'b0000, 10);
        run("add_hi0", 4'h0, 8'h01, 8'h02, 4'b0000, 8'h03, 8'h00, 4'b0000, 2);
        // abort a multiply with an asynchronous reset between edges
        issue("mul_abort", 4'hF, 8'hFF, 8'hFF, 4'b0000, 8'h00, 8'h00, 4'b0000, 10, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_lo", out_lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", done, 0);
        rst_n = 1;
        run("add_post", 4'h0, 8'h03, 8'h04, 4'b0000, 8'h07, 8'h00, 4'b0000, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
